// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR burst scheduler.
package lfsr_sched_pkg;

  localparam int NUM_REQ = 2;
  localparam int MOD_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: ptr names the requester favoured on a tie.
module rr_arb2
  import lfsr_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic [NUM_REQ-1:0] win
);

  // a lone (or absent) request passes straight through as the one-hot winner
  always_comb begin
    win = 2'b00;
    if (req == 2'b11) begin
      win = ptr ? 2'b10 : 2'b01;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/lfsr_sched.sv
// Schedules LFSR bursts for two requesters and returns last sample + signature.
// Optional macro LFSR_SCHED_SIG_EN enables the rotate-xor burst signature.
module lfsr_sched
  import lfsr_sched_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int Q_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*MOD_W-1:0]     req_mode,
  input  logic [2*LEN_W-1:0]     req_len,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   lfsr_rst,
  output logic [MOD_W-1:0]       lfsr_mod,
  input  logic [Q_W-1:0]         lfsr_q,
  output logic                   res_valid,
  input  logic                   res_ready,
  output req_id_t                res_id,
  output logic [Q_W-1:0]         res_data,
  output logic [Q_W-1:0]         res_sig
);

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t              state_r, state_nx_s;
  req_id_t             ptr_r, id_r, res_id_r;
  logic [MOD_W-1:0]    mode_r, mode_nx_s, win_mode_s, lfsr_mod_r;
  logic [LEN_W-1:0]    len_r, win_len_s;
  logic [LEN_W:0]      cnt_r;
  logic [NUM_REQ-1:0]  win_s, gnt_r;
  logic                win_id_s, grant_s, burst_nx_s;
  logic                lfsr_rst_r, res_valid_r;
  logic [Q_W-1:0]      res_data_r;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr_r),
    .win (win_s)
  );

  assign win_id_s   = win_s[1];
  assign win_mode_s = win_id_s ? req_mode[2*MOD_W-1:MOD_W] : req_mode[MOD_W-1:0];
  assign win_len_s  = win_id_s ? req_len[2*LEN_W-1:LEN_W]  : req_len[LEN_W-1:0];
  assign grant_s    = (state_r == ST_IDLE) && (req != 2'b00);
  assign mode_nx_s  = grant_s ? win_mode_s : mode_r;
  assign burst_nx_s = (state_nx_s == ST_SEED) || (state_nx_s == ST_RUN);

  // next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req != 2'b00) state_nx_s = ST_SEED;
        else              state_nx_s = ST_IDLE;
      end
      ST_SEED: state_nx_s = ST_RUN;
      ST_RUN: begin
        if (cnt_r == CNT_ONE) state_nx_s = ST_DONE;
        else                  state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        if (res_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nx_s;
  end

  // burst datapath and registered outputs, derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r       <= 1'b0;
      id_r        <= 1'b0;
      mode_r      <= {MOD_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      cnt_r       <= {(LEN_W+1){1'b0}};
      gnt_r       <= 2'b00;
      lfsr_rst_r  <= 1'b1;
      lfsr_mod_r  <= {MOD_W{1'b0}};
      res_valid_r <= 1'b0;
      res_id_r    <= 1'b0;
      res_data_r  <= {Q_W{1'b0}};
    end else begin
      gnt_r       <= grant_s ? win_s : 2'b00;
      lfsr_rst_r  <= (state_nx_s != ST_RUN);
      lfsr_mod_r  <= burst_nx_s ? mode_nx_s : {MOD_W{1'b0}};
      res_valid_r <= (state_nx_s == ST_DONE);
      mode_r      <= mode_nx_s;
      if (grant_s) begin
        id_r  <= win_id_s;
        len_r <= win_len_s;
      end
      case (state_r)
        // a zero length field sets the extra MSB, giving 2^LEN_W samples
        ST_SEED: cnt_r <= {(len_r == {LEN_W{1'b0}}), len_r};
        ST_RUN: begin
          cnt_r      <= cnt_r - CNT_ONE;
          res_data_r <= lfsr_q;
          if (cnt_r == CNT_ONE) res_id_r <= id_r;
        end
        ST_DONE: begin
          if (res_ready) ptr_r <= ~id_r;
        end
        default: ;
      endcase
    end
  end

`ifdef LFSR_SCHED_SIG_EN
  logic [Q_W-1:0] sig_r;

  function automatic logic [Q_W-1:0] rotl1(input logic [Q_W-1:0] v);
    return {v[Q_W-2:0], v[Q_W-1]};
  endfunction

  // burst signature: rotate-left then fold in each sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_r <= {Q_W{1'b0}};
    end else if (state_r == ST_SEED) begin
      sig_r <= {Q_W{1'b0}};
    end else if (state_r == ST_RUN) begin
      sig_r <= rotl1(sig_r) ^ lfsr_q;
    end else begin
      sig_r <= sig_r;
    end
  end

  assign res_sig = sig_r;
`else
  assign res_sig = {Q_W{1'b0}};
`endif

  assign gnt       = gnt_r;
  assign lfsr_rst  = lfsr_rst_r;
  assign lfsr_mod  = lfsr_mod_r;
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_data  = res_data_r;

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed scoreboard bench for lfsr_sched with a counting stub LFSR.
module tb_lfsr_sched;

  localparam int LEN_W = 4;
  localparam int Q_W   = 4;

  typedef struct {
    logic           id;
    logic [Q_W-1:0] data;
    logic [Q_W-1:0] sig;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req;
  logic [5:0]         req_mode;
  logic [2*LEN_W-1:0] req_len;
  logic [1:0]         gnt;
  logic               lfsr_rst;
  logic [2:0]         lfsr_mod;
  logic [Q_W-1:0]     lfsr_q;
  logic               res_valid;
  logic               res_ready;
  logic               res_id;
  logic [Q_W-1:0]     res_data;
  logic [Q_W-1:0]     res_sig;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // stub LFSR: cleared while lfsr_rst is high, otherwise counts up
  always_ff @(posedge clk) begin
    if (lfsr_rst) lfsr_q <= 4'd0;
    else          lfsr_q <= lfsr_q + 4'd1;
  end

  lfsr_sched #(.LEN_W(LEN_W), .Q_W(Q_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_mode  (req_mode),
    .req_len   (req_len),
    .gnt       (gnt),
    .lfsr_rst  (lfsr_rst),
    .lfsr_mod  (lfsr_mod),
    .lfsr_q    (lfsr_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_sig   (res_sig)
  );

  function automatic exp_t model(input logic id, input logic [LEN_W-1:0] len);
    exp_t           e;
    int             n;
    logic [Q_W-1:0] s;
    n = (len == 4'd0) ? 16 : int'(len);
    s = 4'd0;
    for (int i = 0; i < n; i++) s = {s[2:0], s[3]} ^ 4'(i);
    e.id   = id;
    e.data = 4'(n - 1);
`ifdef LFSR_SCHED_SIG_EN
    e.sig  = s;
`else
    e.sig  = 4'd0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; res_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_gnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 50; i++) begin
      step();
      if (gnt != 2'b00) begin
        g = gnt;
        break;
      end
    end
    chk("gnt_seen", 32'(g != 2'b00), 32'd1);
  endtask

  task automatic wait_result(input logic [2:0] mode, output int run_n, output int mod_n);
    logic found;
    found = 1'b0; run_n = 0; mod_n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (res_valid) begin
        found = 1'b1;
        break;
      end
      if (!lfsr_rst) run_n++;
      if (lfsr_mod == mode) mod_n++;
    end
    chk("result_seen", 32'(found), 32'd1);
  endtask

  task automatic check_result();
    exp_t e;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("res_id", 32'(res_id), 32'(e.id));
      chk("res_data", 32'(res_data), 32'(e.data));
      chk("res_sig", 32'(res_sig), 32'(e.sig));
      chk("done_mod", 32'(lfsr_mod), 32'd0);
      chk("done_lfsr_rst", 32'(lfsr_rst), 32'd1);
    end
  endtask

  initial begin
    logic [1:0] g;
    logic       exp_id;
    int         run_n, mod_n;
    exp_t       ed;

    rst_n = 1'b0; req = 2'b00; req_mode = 6'd0; req_len = 8'd0; res_ready = 1'b0;
    repeat (2) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_lfsr_rst", 32'(lfsr_rst), 32'd1);
    chk("rst_mod", 32'(lfsr_mod), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_sig", 32'(res_sig), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_gnt", 32'(gnt), 32'd0);

    // single burst: mode 5, length 4
    req_mode = {3'd0, 3'd5}; req_len = {4'd0, 4'd4}; req = 2'b01;
    step();
    chk("a_gnt", 32'(gnt), 32'd1);
    chk("a_seed_mod", 32'(lfsr_mod), 32'd5);
    chk("a_seed_rst", 32'(lfsr_rst), 32'd1);
    req = 2'b00;
    sb_q.push_back(model(1'b0, 4'd4));
    wait_result(3'd5, run_n, mod_n);
    chk("a_run_cycles", 32'(run_n), 32'd4);
    chk("a_mod_cycles", 32'(mod_n + 1), 32'd5);
    check_result();
    res_ready = 1'b1;
    step();
    chk("a_ack_valid", 32'(res_valid), 32'd0);
    step();
    chk("a_ready_idle_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // round-robin with both requesters held
    do_reset();
    req_mode = {3'd6, 3'd1}; req_len = {4'd3, 4'd2}; res_ready = 1'b1; req = 2'b11;
    for (int b = 0; b < 4; b++) begin
      exp_id = (b % 2 == 1);
      wait_gnt(g);
      chk("rr_gnt", 32'(g), exp_id ? 32'd2 : 32'd1);
      chk("rr_mod", 32'(lfsr_mod), exp_id ? 32'd6 : 32'd1);
      sb_q.push_back(model(exp_id, exp_id ? 4'd3 : 4'd2));
      wait_result(exp_id ? 3'd6 : 3'd1, run_n, mod_n);
      chk("rr_run_cycles", 32'(run_n), exp_id ? 32'd3 : 32'd2);
      check_result();
    end
    req = 2'b00; res_ready = 1'b0;
    step();

    // length field 0 means 16 samples, then hold DONE with ready low
    do_reset();
    req_mode = {3'd0, 3'd3}; req_len = {4'd0, 4'd0}; req = 2'b01;
    wait_gnt(g);
    chk("c_gnt", 32'(g), 32'd1);
    req = 2'b00;
    sb_q.push_back(model(1'b0, 4'd0));
    wait_result(3'd3, run_n, mod_n);
    chk("c_run_cycles", 32'(run_n), 32'd16);
    check_result();
    ed = model(1'b0, 4'd0);
    req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_id", 32'(res_id), 32'(ed.id));
      chk("hold_data", 32'(res_data), 32'(ed.data));
      chk("hold_sig", 32'(res_sig), 32'(ed.sig));
      chk("hold_gnt", 32'(gnt), 32'd0);
    end
    res_ready = 1'b1;
    step();
    chk("hold_ack_valid", 32'(res_valid), 32'd0);
    req = 2'b00; res_ready = 1'b0;
    step();
    chk("no_queued_gnt", 32'(gnt), 32'd0);

    // reset in the middle of a burst aborts it without a result
    req_mode = {3'd0, 3'd7}; req_len = {4'd0, 4'd8}; req = 2'b01;
    wait_gnt(g);
    req = 2'b00;
    begin
      logic reached;
      reached = 1'b0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (!lfsr_rst && lfsr_q == 4'd6) begin
          reached = 1'b1;
          break;
        end
      end
      chk("e_reach_cnt2", 32'(reached), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("e_valid", 32'(res_valid), 32'd0);
    chk("e_lfsr_rst", 32'(lfsr_rst), 32'd1);
    chk("e_mod", 32'(lfsr_mod), 32'd0);
    chk("e_gnt", 32'(gnt), 32'd0);
    step();
    rst_n = 1'b1;
    req_mode = {3'd2, 3'd0}; req_len = {4'd3, 4'd0}; req = 2'b10;
    step();
    chk("e_new_gnt", 32'(gnt), 32'd2);
    chk("e_new_mod", 32'(lfsr_mod), 32'd2);
    req = 2'b00;
    sb_q.push_back(model(1'b1, 4'd3));
    wait_result(3'd2, run_n, mod_n);
    chk("e_run_cycles", 32'(run_n), 32'd3);
    check_result();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_sched.md
LFSR_SCHED -- requirements
Module: lfsr_sched

Interface
REQ-001 Parameter LEN_W, default 4, burst-length field width; burst of 0 means 2^LEN_W samples.
REQ-002 Parameter Q_W, default 4, LFSR output width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 req  in  2  per-requester request; held until matching gnt bit.
REQ-006 req_mode  in  6  mode per requester, [2:0]=req0, [5:3]=req1.
REQ-007 req_len  in  2*LEN_W  burst length per requester, low field=req0.
REQ-008 gnt  out  2  one-hot, one-cycle acceptance pulse.
REQ-009 lfsr_rst  out  1  active-high reset to the shared LFSR.
REQ-010 lfsr_mod  out  3  mode select to the shared LFSR.
REQ-011 lfsr_q  in  Q_W  LFSR state.
REQ-012 res_valid / res_ready  out / in  1 each  result handshake.
REQ-013 res_id  out  1  requester that owns the result.
REQ-014 res_data / res_sig  out  Q_W each  last sample / burst signature.

Function
REQ-015 FSM SHALL have states IDLE, SEED, RUN, DONE.
REQ-016 IDLE: when req!=0, the next edge latches winner id, its mode and its len, pulses gnt[id] for the following cycle and enters SEED.
REQ-017 Arbitration SHALL be round-robin: priority pointer starts at 0 and moves to the non-winner on each DONE handshake; a lone requester always wins.
REQ-018 SEED SHALL last exactly one cycle, then enter RUN with counter = len (0 → 2^LEN_W) and sig = 0.
REQ-019 lfsr_rst SHALL be 1 in IDLE, SEED and DONE, and 0 only in RUN.
REQ-020 lfsr_mod SHALL equal latched mode in SEED and RUN, and 0 otherwise.
REQ-021 RUN: each cycle samples lfsr_q into res_data, updates sig = rotl(sig,1) XOR lfsr_q and decrements the counter; after the last sample it enters DONE.
REQ-022 DONE: res_valid=1 and res_id/res_data/res_sig SHALL be stable until res_valid&res_ready, then enter IDLE.
REQ-023 Requests arriving outside IDLE SHALL be ignored (not queued); gnt SHALL be 0 outside the SEED cycle.
REQ-024 Withdrawn req before grant SHALL produce no grant; a req mode/len change after grant SHALL not affect the burst.
REQ-025 res_ready high without res_valid SHALL have no effect.

Reset
REQ-026 rst_n low in any state SHALL force IDLE, pointer=0, gnt=0, res_valid=0, res_id/res_data/res_sig=0, lfsr_mod=0 and lfsr_rst=1, aborting any burst without a result.

Configuration
REQ-027 Macro LFSR_SCHED_SIG_EN defined: res_sig carries the REQ-021 signature.
REQ-028 Macro LFSR_SCHED_SIG_EN undefined: signature logic is absent and res_sig is tied to 0; all else is unchanged.

Structure
REQ-029 Package lfsr_sched_pkg SHALL hold the FSM state enum, the requester-id type and the constants NUM_REQ=2 and MOD_W=3.
REQ-030 The arbiter SHALL be a sub-module rr_arb2 (req, pointer → one-hot winner, combinational).

Verification (bench uses stub LFSR: reset→0, else +1)
REQ-031 req=01, mode0=5, len0=4 → gnt=01 for 1 cycle, lfsr_mod=5 for 5 cycles, then res_valid with res_id=0, res_data=3, res_sig=3.
REQ-032 req=11 held, res_ready=1 → grants in order 0,1,0,1 across four bursts.
REQ-033 len0=0 → 16 RUN cycles, res_data=0xF.
REQ-034 res_ready=0 for 10 cycles in DONE → outputs stable, no new gnt although req=11.
REQ-035 rst_n low mid-RUN (counter=2) → IDLE next cycle, res_valid=0, lfsr_rst=1; after release, a new req=10 gets gnt=10.
REQ-036 Build without LFSR_SCHED_SIG_EN, rerun REQ-031 → res_sig=0, res_data=3.
